// File: rtl/multi_click_detector_pkg.sv
// Shared definitions for the multi-click detector: FSM state encoding and the
// helpers that derive the inter-click window length and the click-count width.
package multi_click_detector_pkg;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    function automatic int unsigned window_cycles(input int unsigned clocks_per_usec,
                                                  input int unsigned window_msec);
        return clocks_per_usec * window_msec * 32'd1000;
    endfunction

    function automatic int unsigned count_width(input int unsigned max_clicks);
        return $clog2(max_clicks + 32'd1);
    endfunction

endpackage

// File: rtl/multi_click_detector_if.sv
// Press input and gesture report outputs of the multi-click detector.
interface multi_click_detector_if
    import multi_click_detector_pkg::*;
#(
    parameter int unsigned CW = 2
) ();
    logic          PRESS;
    logic [CW-1:0] COUNT;
    logic          VALID;
    logic          BUSY;

    modport master (output PRESS, input COUNT, input VALID, input BUSY);
    modport slave  (input PRESS, output COUNT, output VALID, output BUSY);
endinterface

// File: rtl/multi_click_detector_window_timer.sv
// Loadable down-counter that stops at zero and flags the cycle its count is one.
module window_timer
    import multi_click_detector_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         LOAD,
    input  logic [W-1:0] LOAD_VALUE,
    output logic         EXPIRE
);
    logic [W-1:0] count_q;

    // Count register: load has priority, otherwise decrement until zero.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= {W{1'b0}};
        end else if (LOAD) begin
            count_q <= LOAD_VALUE;
        end else if (count_q != {W{1'b0}}) begin
            count_q <= count_q - W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign EXPIRE = (count_q == W'(1));
endmodule

// File: rtl/multi_click_detector.sv
// Groups debounced press pulses arriving within the inter-click window into a
// single gesture and reports its click count with a one-cycle VALID strobe.
module multi_click_detector
    import multi_click_detector_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_USEC   = 125,
    parameter int unsigned CLICK_WINDOW_MSEC = 300,
    parameter int unsigned MAX_CLICKS        = 3
) (
    input  logic                   CLK,
    input  logic                   RESET,
    multi_click_detector_if.slave  bus
);
    localparam int unsigned WINDOW = window_cycles(CLOCKS_PER_USEC, CLICK_WINDOW_MSEC);
    localparam int unsigned TW     = $clog2(WINDOW + 32'd1);
    localparam int unsigned CW     = count_width(MAX_CLICKS);
    // The press cycle itself is the first cycle of the window, hence WINDOW-1.
    localparam logic [TW-1:0] RELOAD  = TW'(WINDOW - 32'd1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CLICKS);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] click_cnt_q, click_cnt_d;
    logic [CW-1:0] count_q;
    logic          valid_q, busy_q;

    logic          report_s;
    logic [CW-1:0] report_cnt_s;
    logic [CW-1:0] inc_s;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_value_s;
    logic          tmr_expire_s;

    window_timer #(.W(TW)) u_timer (
        .CLK        (CLK),
        .RESET      (RESET),
        .LOAD       (tmr_load_s),
        .LOAD_VALUE (tmr_value_s),
        .EXPIRE     (tmr_expire_s)
    );

    assign inc_s = click_cnt_q + ONE;

    // Next-state logic; a press always wins over a coincident timer expiry.
    always_comb begin
        state_d      = state_q;
        click_cnt_d  = click_cnt_q;
        report_s     = 1'b0;
        report_cnt_s = click_cnt_q;
        tmr_load_s   = 1'b0;
        tmr_value_s  = RELOAD;
        case (state_q)
            ST_IDLE: begin
                if (bus.PRESS && (MAX_CNT == ONE)) begin
                    report_s     = 1'b1;
                    report_cnt_s = ONE;
                end else if (bus.PRESS) begin
                    click_cnt_d = ONE;
                    tmr_load_s  = 1'b1;
                    state_d     = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (bus.PRESS && (click_cnt_q >= MAX_CNT - ONE)) begin
                    report_s     = 1'b1;
                    report_cnt_s = MAX_CNT;
                    click_cnt_d  = {CW{1'b0}};
                    tmr_load_s   = 1'b1;
                    tmr_value_s  = {TW{1'b0}};
                    state_d      = ST_IDLE;
                end else if (bus.PRESS) begin
                    click_cnt_d = inc_s;
                    tmr_load_s  = 1'b1;
                end else if (tmr_expire_s) begin
                    report_s    = 1'b1;
                    click_cnt_d = {CW{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                click_cnt_d = {CW{1'b0}};
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State, click counter and registered report outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            click_cnt_q <= {CW{1'b0}};
            count_q     <= {CW{1'b0}};
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            click_cnt_q <= click_cnt_d;
            valid_q     <= report_s;
            busy_q      <= (state_d == ST_COLLECT);
            if (report_s) begin
                count_q <= report_cnt_s;
            end else begin
                count_q <= count_q;
            end
        end
    end

    assign bus.COUNT = count_q;
    assign bus.VALID = valid_q;
    assign bus.BUSY  = busy_q;
endmodule

// File: tb/tb_multi_click_detector.sv
// Scoreboard bench for multi_click_detector with WINDOW=1000 and MAX_CLICKS=3.
module tb_multi_click_detector;
    import multi_click_detector_pkg::*;

    typedef struct { int cyc; int cnt; } vexp_t;
    typedef struct { int cyc; int b;   } bexp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   cyc = 0;
    int   base = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_cnt = 0;
    vexp_t vq[$];
    bexp_t bq[$];

    multi_click_detector_if #(.CW(2)) bus ();

    multi_click_detector #(
        .CLOCKS_PER_USEC   (1),
        .CLICK_WINDOW_MSEC (1),
        .MAX_CLICKS        (3)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, got, exp, cyc - base);
    endtask

    task automatic exp_valid(input int rel, input int cnt);
        vexp_t e;
        e.cyc = base + rel;
        e.cnt = cnt;
        vq.push_back(e);
        last_cnt = cnt;
    endtask

    task automatic exp_busy(input int rel, input int b);
        bexp_t e;
        e.cyc = base + rel;
        e.b = b;
        bq.push_back(e);
    endtask

    task automatic wait_until(input int n);
        while (cyc - base < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic press_at(input int n);
        wait_until(n);
        bus.PRESS = 1'b1;
        @(posedge CLK);
        #1;
        bus.PRESS = 1'b0;
    endtask

    task automatic start_scenario();
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        bus.PRESS = 1'b0;
        #1;
        chk("reset_busy", int'(bus.BUSY), 0);
        chk("reset_valid", int'(bus.VALID), 0);
        chk("reset_count", int'(bus.COUNT), 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        base = cyc;
    endtask

    task automatic end_scenario(input int n);
        wait_until(n);
        chk("missing_valid", vq.size(), 0);
        chk("count_hold", int'(bus.COUNT), last_cnt);
    endtask

    // Monitor: compares every VALID strobe and scheduled BUSY sample to the queues.
    always @(negedge CLK) begin
        if (!RESET && bus.VALID) begin
            if (vq.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                vexp_t e;
                e = vq.pop_front();
                chk("valid_cycle", cyc - base, e.cyc - base);
                chk("valid_count", int'(bus.COUNT), e.cnt);
            end
        end
        while (bq.size() > 0 && bq[0].cyc <= cyc) begin
            bexp_t b;
            b = bq.pop_front();
            chk("busy", int'(bus.BUSY), b.b);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.PRESS = 1'b0;

        // Single press -> COUNT=1 at 1010.
        start_scenario();
        exp_busy(10, 0); exp_busy(11, 1); exp_busy(1009, 1); exp_busy(1010, 0);
        exp_valid(1010, 1);
        press_at(10);
        end_scenario(1100);

        // Two presses -> one report at 1500.
        start_scenario();
        exp_busy(1010, 1); exp_busy(1500, 0);
        exp_valid(1500, 2);
        press_at(10); press_at(500);
        end_scenario(1600);

        // Three presses -> immediate report at 401.
        start_scenario();
        exp_busy(400, 1); exp_busy(401, 0);
        exp_valid(401, 3);
        press_at(10); press_at(200); press_at(400);
        end_scenario(1500);

        // Press on the timer==1 cycle restarts the window.
        start_scenario();
        exp_busy(1010, 1); exp_busy(2008, 1); exp_busy(2009, 0);
        exp_valid(2009, 2);
        press_at(10); press_at(1009);
        end_scenario(2100);

        // Reset mid-gesture discards it.
        start_scenario();
        exp_busy(299, 1); exp_busy(600, 0); exp_busy(601, 1); exp_busy(1600, 0);
        exp_valid(1600, 1);
        press_at(10);
        wait_until(300);
        RESET = 1'b1;
        #1;
        chk("midreset_busy", int'(bus.BUSY), 0);
        chk("midreset_valid", int'(bus.VALID), 0);
        chk("midreset_count", int'(bus.COUNT), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        press_at(600);
        end_scenario(1700);

        // Press during the VALID cycle starts a new gesture.
        start_scenario();
        exp_busy(1010, 0); exp_busy(1011, 1);
        exp_valid(1010, 1); exp_valid(2010, 1);
        press_at(10); press_at(1010);
        end_scenario(2100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multi_click_detector.md
Name: multi_click_detector

Overview:
- Consumes the single-cycle, fully debounced press pulse produced by the debounced-button stage. Groups presses that arrive within a programmable inter-click window into one gesture.
- Reports the gesture as a click count (single, double, triple, ...) with a one-cycle VALID strobe.
- Sits between the debounced-button stage and the control logic that interprets front-panel buttons.

Parameters:
- CLOCKS_PER_USEC, 125, system clocks per microsecond.
- CLICK_WINDOW_MSEC, 300, maximum gap between consecutive presses of one gesture, in ms.
- MAX_CLICKS, 3, click count at which the gesture is reported immediately; must be ≥ 1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- PRESS  in  1  single-cycle pulse, one per debounced active edge.
- COUNT  out  CW  clicks in the most recently reported gesture; CW = $clog2(MAX_CLICKS+1).
- VALID  out  1  one-cycle strobe; COUNT is valid on this cycle.
- BUSY  out  1  high while a gesture is being collected.

Behaviour:
- Derived constants:
  - WINDOW = CLOCKS_PER_USEC * CLICK_WINDOW_MSEC * 1000.
  - Timer width = $clog2(WINDOW+1).
  - click_cnt width = CW.
- Clocking and reset:
  - All state is registered on posedge CLK.
  - RESET asserted at any time, including mid-gesture: state=IDLE, timer=0, click_cnt=0, COUNT=0, VALID=0, BUSY=0.
  - A gesture in progress is discarded with no VALID.
- FSM, two states:
  - IDLE
    - PRESS=1: click_cnt←1, timer←WINDOW, go to COLLECT.
    - Exception, MAX_CLICKS=1: report immediately and stay IDLE.
  - COLLECT, entered with PRESS=0:
    - timer←timer-1.
    - When timer==1 on this cycle: report and go to IDLE.
  - COLLECT, entered with PRESS=1:
    - click_cnt←click_cnt+1, timer←WINDOW (restart).
    - If click_cnt+1 == MAX_CLICKS: report immediately, go to IDLE, timer←0.
- Report (registered):
  - On the next cycle, VALID=1 for exactly one cycle and COUNT = final click count.
  - COUNT holds that value until the next report.
- Latency:
  - Timeout report: VALID rises exactly WINDOW cycles after the cycle in which the last PRESS was sampled.
  - MAX_CLICKS report: VALID rises 1 cycle after the terminating PRESS.
- BUSY = (state==COLLECT). It is registered, so it goes high the cycle after the first PRESS and low in the same cycle VALID rises.
- Simultaneous PRESS and timer==1: the press wins. It is counted and the timer restarts; no report that cycle.
- PRESS in the cycle VALID is high (state already IDLE): starts a new gesture normally. No press is ever lost.
- Saturation: click_cnt never exceeds MAX_CLICKS and no arithmetic wraps.
- PRESS held high for multiple cycles (protocol violation): each high cycle counts as one press. This is documented, not guarded.

Decomposition:
- State encodings (IDLE, COLLECT) and the WINDOW/width derivations live in a shared `button_defs` include. The debounced-button stage and this block use the same CLOCKS_PER_USEC convention.
- One sub-module: window_timer.
  - Loadable down-counter: LOAD, LOAD_VALUE, EXPIRE pulse when count==1, async active-high RESET.
  - Reusable by the debounced-button stage.

Test Plan (CLOCKS_PER_USEC=1, CLICK_WINDOW_MSEC=1 → WINDOW=1000, MAX_CLICKS=3):
- Single PRESS at cycle 10 → BUSY high cycles 11..1009; VALID=1 with COUNT=1 at cycle 1010 only.
- PRESS at 10 and 500 → one VALID at cycle 1500 with COUNT=2; no VALID at 1010.
- PRESS at 10, 200, 400 → VALID at cycle 401, COUNT=3, BUSY low at 401; no later VALID.
- PRESS at 10 and again exactly at the timer==1 cycle (1009) → no VALID at 1010; VALID at 2009 with COUNT=2.
- PRESS at 10, RESET pulse at 300, PRESS at 600 → outputs 0 immediately on RESET; single VALID at 1600 with COUNT=1.
- PRESS on the same cycle as a timeout VALID (cycle 1010) → first VALID COUNT=1; new gesture yields VALID at 2010 with COUNT=1.
